// File: rtl/vga_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package  : vga_pkg                                                   |
// | Purpose  : Shared VGA stream widths, the pixel/timing bundle type    |
// |            and default overlay image dimensions.                     |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package vga_pkg;

  localparam int HCOUNT_W  = 11;
  localparam int RGB_W     = 12;

  // Default image size for overlay stages (both must be powers of two).
  localparam int DEF_IMG_W = 128;
  localparam int DEF_IMG_H = 128;

  // One pixel of the VGA stream together with its timing.
  typedef struct packed {
    logic [HCOUNT_W-1:0] hcount;
    logic [HCOUNT_W-1:0] vcount;
    logic                hsync;
    logic                vsync;
    logic                hblnk;
    logic                vblnk;
    logic [RGB_W-1:0]    rgb;
  } vga_if_t;

endpackage
`default_nettype wire

// File: rtl/delay_vga.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : delay_vga                                                 |
// | Purpose  : N-stage shift register for the VGA bundle. The last stage |
// |            loads last_rgb in place of the carried colour so the      |
// |            caller can merge a pixel into the stream at the end of    |
// |            the delay line. N must be at least 2.                     |
// | Ports    : clk, rst_n (async, active-low)                            |
// |            din      - bundle entering stage 0                        |
// |            tap_rgb  - colour held in stage N-2 (one before output)   |
// |            last_rgb - colour loaded into the final stage             |
// |            dout     - final stage                                    |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module delay_vga
  import vga_pkg::*;
#(
  parameter int N = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  vga_if_t          din,
  input  logic [RGB_W-1:0] last_rgb,
  output logic [RGB_W-1:0] tap_rgb,
  output vga_if_t          dout
);

  vga_if_t r_stage [N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= din;
      for (int i = 1; i < N; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
      // Later assignment wins: the final colour comes from the caller.
      r_stage[N-1].rgb <= last_rgb;
    end
  end

  assign tap_rgb = r_stage[N-2].rgb;
  assign dout    = r_stage[N-1];

endmodule
`default_nettype wire

// File: rtl/draw_image_ctl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : draw_image_ctl                                            |
// | Purpose  : Overlays an IMG_W x IMG_H image from a synchronous ROM    |
// |            onto the VGA stream. Position is latched once per frame;  |
// |            all timing is delayed 3 clk to match the ROM latency.     |
// | Ports    : clk, rst_n (async, active-low), en (overlay enable)       |
// |            xpos/ypos        - requested top-left corner              |
// |            in_*             - upstream beam position/timing/colour   |
// |            rom_addr/rom_rgb - external ROM, 1 clk read latency       |
// |            out_*            - stream delayed by 3 clk, merged colour |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module draw_image_ctl
  import vga_pkg::*;
#(
  parameter int               IMG_W  = DEF_IMG_W,
  parameter int               IMG_H  = DEF_IMG_H,
  parameter logic [RGB_W-1:0] TRANSP = 12'hF0F
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    en,
  input  logic [11:0]                             xpos,
  input  logic [11:0]                             ypos,
  input  logic [HCOUNT_W-1:0]                     in_hcount,
  input  logic [HCOUNT_W-1:0]                     in_vcount,
  input  logic                                    in_hsync,
  input  logic                                    in_vsync,
  input  logic                                    in_hblnk,
  input  logic                                    in_vblnk,
  input  logic [RGB_W-1:0]                        in_rgb,
  output logic [$clog2(IMG_H)+$clog2(IMG_W)-1:0]  rom_addr,
  input  logic [RGB_W-1:0]                        rom_rgb,
  output logic [HCOUNT_W-1:0]                     out_hcount,
  output logic [HCOUNT_W-1:0]                     out_vcount,
  output logic                                    out_hsync,
  output logic                                    out_vsync,
  output logic                                    out_hblnk,
  output logic                                    out_vblnk,
  output logic [RGB_W-1:0]                        out_rgb
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);

  logic [11:0]      r_x_lat;
  logic [11:0]      r_y_lat;
  logic             w_frame_start;
  logic [11:0]      w_x_cur;
  logic [11:0]      w_y_cur;
  logic [XW-1:0]    w_x_off;
  logic [YW-1:0]    w_y_off;
  logic             w_inside;
  logic [XW+YW-1:0] r_rom_addr;
  logic             r_inside_d1;
  logic             r_inside_d2;
  logic [RGB_W-1:0] w_rgb_d2;
  logic [RGB_W-1:0] w_merged;
  vga_if_t          w_in;
  vga_if_t          w_out;

  // Position is only picked up at the very first pixel of a frame. That
  // pixel must already see the new position, so it bypasses the latch.
  assign w_frame_start = (in_hcount == '0) && (in_vcount == '0);
  assign w_x_cur       = w_frame_start ? xpos : r_x_lat;
  assign w_y_cur       = w_frame_start ? ypos : r_y_lat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x_lat <= '0;
      r_y_lat <= '0;
    end else if (w_frame_start) begin
      r_x_lat <= xpos;
      r_y_lat <= ypos;
    end
  end

  // Only the low address bits of the offset are needed; the low bits of
  // a difference equal the difference of the low bits modulo 2^XW.
  assign w_x_off = in_hcount[XW-1:0] - w_x_cur[XW-1:0];
  assign w_y_off = in_vcount[YW-1:0] - w_y_cur[YW-1:0];

  // Upper bounds use 13 bits so a position near the top of the 12-bit
  // range cannot wrap and make the image reappear at the left/top edge.
  assign w_inside = ({1'b0, in_hcount} >= w_x_cur) &&
                    ({2'b00, in_hcount} < ({1'b0, w_x_cur} + 13'(IMG_W))) &&
                    ({1'b0, in_vcount} >= w_y_cur) &&
                    ({2'b00, in_vcount} < ({1'b0, w_y_cur} + 13'(IMG_H))) &&
                    !in_hblnk && !in_vblnk && en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rom_addr  <= '0;
      r_inside_d1 <= 1'b0;
      r_inside_d2 <= 1'b0;
    end else begin
      r_rom_addr  <= w_inside ? {w_y_off, w_x_off} : '0;
      r_inside_d1 <= w_inside;
      r_inside_d2 <= r_inside_d1;
    end
  end

  assign rom_addr = r_rom_addr;

  always_comb begin
    w_in        = '0;
    w_in.hcount = in_hcount;
    w_in.vcount = in_vcount;
    w_in.hsync  = in_hsync;
    w_in.vsync  = in_vsync;
    w_in.hblnk  = in_hblnk;
    w_in.vblnk  = in_vblnk;
    w_in.rgb    = in_rgb;
  end

  // rom_rgb lines up with stage 2; the merged colour lands in stage 3.
  assign w_merged = (r_inside_d2 && (rom_rgb != TRANSP)) ? rom_rgb : w_rgb_d2;

  delay_vga #(
    .N (3)
  ) u_delay (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (w_in),
    .last_rgb (w_merged),
    .tap_rgb  (w_rgb_d2),
    .dout     (w_out)
  );

  assign out_hcount = w_out.hcount;
  assign out_vcount = w_out.vcount;
  assign out_hsync  = w_out.hsync;
  assign out_vsync  = w_out.vsync;
  assign out_hblnk  = w_out.hblnk;
  assign out_vblnk  = w_out.vblnk;
  assign out_rgb    = w_out.rgb;

endmodule
`default_nettype wire

// File: tb/tb_draw_image_ctl.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | Module   : tb_draw_image_ctl                                         |
// | Purpose  : Directed self-checking bench for draw_image_ctl with a    |
// |            synchronous ROM model returning addr[11:0] (12'hF0F at    |
// |            address 5).                                               |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_draw_image_ctl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [11:0] xpos = '0;
  logic [11:0] ypos = '0;
  logic [10:0] in_hcount = '0;
  logic [10:0] in_vcount = '0;
  logic        in_hsync = 1'b0;
  logic        in_vsync = 1'b0;
  logic        in_hblnk = 1'b0;
  logic        in_vblnk = 1'b0;
  logic [11:0] in_rgb = '0;
  logic [13:0] rom_addr;
  logic [11:0] rom_rgb = '0;
  logic [10:0] out_hcount;
  logic [10:0] out_vcount;
  logic        out_hsync;
  logic        out_vsync;
  logic        out_hblnk;
  logic        out_vblnk;
  logic [11:0] out_rgb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) rom_rgb <= (rom_addr == 14'd5) ? 12'hF0F : rom_addr[11:0];

  draw_image_ctl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .xpos       (xpos),
    .ypos       (ypos),
    .in_hcount  (in_hcount),
    .in_vcount  (in_vcount),
    .in_hsync   (in_hsync),
    .in_vsync   (in_vsync),
    .in_hblnk   (in_hblnk),
    .in_vblnk   (in_vblnk),
    .in_rgb     (in_rgb),
    .rom_addr   (rom_addr),
    .rom_rgb    (rom_rgb),
    .out_hcount (out_hcount),
    .out_vcount (out_vcount),
    .out_hsync  (out_hsync),
    .out_vsync  (out_vsync),
    .out_hblnk  (out_hblnk),
    .out_vblnk  (out_vblnk),
    .out_rgb    (out_rgb)
  );

  task automatic drive(input logic [10:0] h, input logic [10:0] v, input logic hb,
                       input logic vb, input logic hs, input logic vs, input logic [11:0] rgb);
    in_hcount = h; in_vcount = v; in_hblnk = hb; in_vblnk = vb;
    in_hsync = hs; in_vsync = vs; in_rgb = rgb;
  endtask

  // Blanked pixel that never hits the frame-start position.
  task automatic drive_filler();
    drive(11'd1200, 11'd1, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000);
  endtask

  task automatic frame_start(input logic [11:0] x, input logic [11:0] y);
    xpos = x; ypos = y;
    drive(11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
    @(posedge clk); #1;
    drive_filler();
  endtask

  // Sends one pixel, returns rom_addr 1 clk later and out_* 3 clk later.
  task automatic run_pix(input logic [10:0] h, input logic [10:0] v, input logic hb,
                         input logic vb, input logic [11:0] rgb, output logic [13:0] addr,
                         output logic [11:0] orgb, output logic [10:0] oh, output logic [10:0] ov);
    drive(h, v, hb, vb, 1'b0, 1'b0, rgb);
    @(posedge clk); #1;
    addr = rom_addr;
    drive_filler();
    @(posedge clk);
    @(posedge clk); #1;
    orgb = out_rgb; oh = out_hcount; ov = out_vcount;
  endtask

  task automatic test_reset();
    logic [13:0] a; logic [11:0] o; logic [10:0] h; logic [10:0] v;
    rst_n = 1'b0; en = 1'b1; xpos = 12'd77; ypos = 12'd33;
    drive(11'd0, 11'd0, 1'b0, 1'b0, 1'b1, 1'b1, 12'hFFF);
    repeat (3) @(posedge clk); #1;
    checks++; if (out_rgb !== 12'h000) begin errors++; $display("FAIL reset_rgb: got %h expected 000", out_rgb); end
    checks++; if ({out_hcount, out_vcount} !== 22'd0) begin errors++; $display("FAIL reset_count: got %0d,%0d expected 0,0", out_hcount, out_vcount); end
    checks++; if ({out_hsync, out_vsync, out_hblnk, out_vblnk} !== 4'b0000) begin errors++; $display("FAIL reset_sync: got %b expected 0000", {out_hsync, out_vsync, out_hblnk, out_vblnk}); end
    checks++; if (rom_addr !== 14'd0) begin errors++; $display("FAIL reset_addr: got %h expected 0000", rom_addr); end
    drive_filler();
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    // Latch was cleared to (0,0): pixel (5,5) maps to address {5,5}.
    run_pix(11'd5, 11'd5, 1'b0, 1'b0, 12'h111, a, o, h, v);
    checks++; if (a !== 14'h0285) begin errors++; $display("FAIL reset_latch_addr: got %h expected 0285", a); end
    checks++; if (o !== 12'h285) begin errors++; $display("FAIL reset_latch_rgb: got %h expected 285", o); end
  endtask

  task automatic test_image();
    logic [13:0] a; logic [11:0] o; logic [10:0] h; logic [10:0] v;
    frame_start(12'd100, 12'd50);
    run_pix(11'd100, 11'd50, 1'b0, 1'b0, 12'hABC, a, o, h, v);
    checks++; if (a !== 14'h0000) begin errors++; $display("FAIL img_first_addr: got %h expected 0000", a); end
    checks++; if (o !== 12'h000) begin errors++; $display("FAIL img_first_rgb: got %h expected 000", o); end
    checks++; if ({h, v} !== {11'd100, 11'd50}) begin errors++; $display("FAIL img_first_pos: got %0d,%0d expected 100,50", h, v); end
    run_pix(11'd227, 11'd177, 1'b0, 1'b0, 12'hABC, a, o, h, v);
    checks++; if (a !== 14'h3FFF) begin errors++; $display("FAIL img_last_addr: got %h expected 3fff", a); end
    checks++; if (o !== 12'hFFF) begin errors++; $display("FAIL img_last_rgb: got %h expected fff", o); end
    run_pix(11'd228, 11'd50, 1'b0, 1'b0, 12'h456, a, o, h, v);
    checks++; if (o !== 12'h456) begin errors++; $display("FAIL img_right_edge: got %h expected 456", o); end
    checks++; if (a !== 14'h0000) begin errors++; $display("FAIL img_right_addr: got %h expected 0000", a); end
    run_pix(11'd110, 11'd60, 1'b0, 1'b0, 12'h789, a, o, h, v);
    checks++; if (o !== 12'h50A) begin errors++; $display("FAIL img_mid_rgb: got %h expected 50a", o); end
    run_pix(11'd100, 11'd178, 1'b0, 1'b0, 12'h321, a, o, h, v);
    checks++; if (o !== 12'h321) begin errors++; $display("FAIL img_bottom_edge: got %h expected 321", o); end
    run_pix(11'd99, 11'd50, 1'b0, 1'b0, 12'h654, a, o, h, v);
    checks++; if (o !== 12'h654) begin errors++; $display("FAIL img_left_edge: got %h expected 654", o); end
  endtask

  task automatic test_colour_key();
    logic [13:0] a; logic [11:0] o; logic [10:0] h; logic [10:0] v;
    run_pix(11'd105, 11'd50, 1'b0, 1'b0, 12'h123, a, o, h, v);
    checks++; if (a !== 14'd5) begin errors++; $display("FAIL key_addr: got %h expected 0005", a); end
    checks++; if (o !== 12'h123) begin errors++; $display("FAIL key_rgb: got %h expected 123", o); end
  endtask

  task automatic test_blanking();
    logic [13:0] a; logic [11:0] o; logic [10:0] h; logic [10:0] v;
    run_pix(11'd110, 11'd60, 1'b1, 1'b0, 12'h2AA, a, o, h, v);
    checks++; if (o !== 12'h2AA) begin errors++; $display("FAIL hblnk_rgb: got %h expected 2aa", o); end
    checks++; if (a !== 14'd0) begin errors++; $display("FAIL hblnk_addr: got %h expected 0000", a); end
    run_pix(11'd110, 11'd60, 1'b0, 1'b1, 12'h2BB, a, o, h, v);
    checks++; if (o !== 12'h2BB) begin errors++; $display("FAIL vblnk_rgb: got %h expected 2bb", o); end
  endtask

  task automatic test_midframe();
    logic [13:0] a; logic [11:0] o; logic [10:0] h; logic [10:0] v;
    frame_start(12'd100, 12'd150);
    xpos = 12'd300;
    run_pix(11'd100, 11'd200, 1'b0, 1'b0, 12'h111, a, o, h, v);
    checks++; if (o !== 12'h900) begin errors++; $display("FAIL mid_old_pos: got %h expected 900", o); end
    run_pix(11'd300, 11'd200, 1'b0, 1'b0, 12'h222, a, o, h, v);
    checks++; if (o !== 12'h222) begin errors++; $display("FAIL mid_new_early: got %h expected 222", o); end
    frame_start(12'd300, 12'd150);
    run_pix(11'd300, 11'd200, 1'b0, 1'b0, 12'h333, a, o, h, v);
    checks++; if (o !== 12'h900) begin errors++; $display("FAIL next_new_pos: got %h expected 900", o); end
    run_pix(11'd100, 11'd200, 1'b0, 1'b0, 12'h444, a, o, h, v);
    checks++; if (o !== 12'h444) begin errors++; $display("FAIL next_old_gone: got %h expected 444", o); end
  endtask

  task automatic test_bypass();
    logic [13:0] a; logic [11:0] o; logic [10:0] h; logic [10:0] v;
    xpos = 12'd0; ypos = 12'd0;
    run_pix(11'd0, 11'd0, 1'b0, 1'b0, 12'h555, a, o, h, v);
    checks++; if (o !== 12'h000) begin errors++; $display("FAIL bypass_rgb: got %h expected 000", o); end
    run_pix(11'd3, 11'd0, 1'b0, 1'b0, 12'h666, a, o, h, v);
    checks++; if (o !== 12'h003) begin errors++; $display("FAIL bypass_latched: got %h expected 003", o); end
  endtask

  task automatic test_partial();
    logic [13:0] a; logic [11:0] o; logic [10:0] h; logic [10:0] v;
    frame_start(12'd1000, 12'd700);
    run_pix(11'd1000, 11'd700, 1'b0, 1'b0, 12'h777, a, o, h, v);
    checks++; if (o !== 12'h000) begin errors++; $display("FAIL part_corner: got %h expected 000", o); end
    run_pix(11'd1023, 11'd767, 1'b0, 1'b0, 12'h777, a, o, h, v);
    checks++; if (a !== 14'h2197) begin errors++; $display("FAIL part_last_addr: got %h expected 2197", a); end
    checks++; if (o !== 12'h197) begin errors++; $display("FAIL part_last_rgb: got %h expected 197", o); end
    run_pix(11'd1024, 11'd700, 1'b1, 1'b0, 12'h888, a, o, h, v);
    checks++; if (o !== 12'h888) begin errors++; $display("FAIL part_col24: got %h expected 888", o); end
    run_pix(11'd1000, 11'd768, 1'b0, 1'b1, 12'h999, a, o, h, v);
    checks++; if (o !== 12'h999) begin errors++; $display("FAIL part_row68: got %h expected 999", o); end
    run_pix(11'd5, 11'd700, 1'b0, 1'b0, 12'hAAA, a, o, h, v);
    checks++; if (o !== 12'hAAA) begin errors++; $display("FAIL part_wrap_x: got %h expected aaa", o); end
    run_pix(11'd1000, 11'd3, 1'b0, 1'b0, 12'hBBB, a, o, h, v);
    checks++; if (o !== 12'hBBB) begin errors++; $display("FAIL part_wrap_y: got %h expected bbb", o); end
  endtask

  // Back-to-back pixels; en off for the first half, on for the second.
  task automatic test_back_to_back();
    logic [11:0] exp_rgb;
    frame_start(12'd100, 12'd50);
    for (int k = 0; k < 18; k++) begin
      if (k < 16) begin
        en = (k >= 8);
        drive(11'(100 + k), 11'd50, 1'b0, 1'b0, k[0], k[1], 12'(12'h800 + k));
      end else begin
        drive_filler();
      end
      @(posedge clk); #1;
      if (k >= 2) begin
        int j;
        j = k - 2;
        exp_rgb = (j >= 8) ? 12'(j) : 12'(12'h800 + j);
        checks++;
        if (out_rgb !== exp_rgb) begin
          errors++; $display("FAIL b2b_rgb[%0d]: got %h expected %h", j, out_rgb, exp_rgb);
        end
        checks++;
        if ({out_hcount, out_vcount, out_hsync, out_vsync} !== {11'(100 + j), 11'd50, j[0], j[1]}) begin
          errors++; $display("FAIL b2b_timing[%0d]: got %0d,%0d,%b%b expected %0d,50,%b%b", j,
                             out_hcount, out_vcount, out_hsync, out_vsync, 100 + j, j[0], j[1]);
        end
      end
    end
    en = 1'b1;
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 4; k++) begin
      drive(11'(110 + k), 11'd60, 1'b0, 1'b0, 1'b1, 1'b1, 12'hCCC);
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({out_rgb, out_hcount, out_vcount} !== 34'd0) begin errors++; $display("FAIL midrst_out: got %h,%0d,%0d expected 0,0,0", out_rgb, out_hcount, out_vcount); end
    checks++; if ({out_hsync, out_vsync, rom_addr} !== 16'd0) begin errors++; $display("FAIL midrst_sync_addr: got %b%b,%h expected 00,0000", out_hsync, out_vsync, rom_addr); end
    drive(11'd200, 11'd60, 1'b0, 1'b0, 1'b0, 1'b0, 12'h9AB);
    #1 rst_n = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    checks++; if ({out_rgb, out_hcount} !== 23'd0) begin errors++; $display("FAIL flush_zero: got %h,%0d expected 0,0", out_rgb, out_hcount); end
    @(posedge clk); #1;
    checks++; if ({out_rgb, out_hcount} !== {12'h9AB, 11'd200}) begin errors++; $display("FAIL flush_first: got %h,%0d expected 9ab,200", out_rgb, out_hcount); end
  endtask

  initial begin
    test_reset();
    test_image();
    test_colour_key();
    test_blanking();
    test_midframe();
    test_bypass();
    test_partial();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
